// File: rtl/softsign_divider.sv
// Softsign activation X/(1+|X|) via a sequential restoring divider, one quotient bit per cycle.
// Define SOFTSIGN_ROUND_EN for round-half-up of the magnitude (one extra iteration, clamped).
module softsign_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             CLOCK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] denom,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_err
);

`ifdef SOFTSIGN_ROUND_EN
  localparam int ITER = FRAC_BITS + 1;
`else
  localparam int ITER = FRAC_BITS;
`endif
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, SIGN} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   x_q, denom_q, mag;
  logic               sign_q, err_q, load_err, quo_bit;
  logic [WIDTH:0]     rem_q, rem_sh, rem_nxt;
  logic [ITER-1:0]    quo_q;
  logic [CW-1:0]      count_q;
  logic [FRAC_BITS-1:0] mag_q;
  logic [WIDTH-1:0]   mag_ext, signed_res;
`ifdef SOFTSIGN_ROUND_EN
  logic [FRAC_BITS:0] rounded;
`endif

  // Unsigned magnitude; the most negative X maps to 2^(WIDTH-1) without overflow.
  assign mag      = x_q[WIDTH-1] ? (WIDTH'(0) - x_q) : x_q;
  assign load_err = (denom_q == '0) || (denom_q <= mag);

  // Remainder stays below denom, so the shifted value always fits in WIDTH+1 bits.
  assign rem_sh  = rem_q << 1;
  assign quo_bit = rem_sh >= {1'b0, denom_q};
  assign rem_nxt = quo_bit ? (rem_sh - {1'b0, denom_q}) : rem_sh;

  always_comb begin
`ifdef SOFTSIGN_ROUND_EN
    rounded = {1'b0, quo_q[ITER-1:1]} + {{FRAC_BITS{1'b0}}, quo_q[0]};
`endif
    mag_q = '1;
    if (!err_q) begin
`ifdef SOFTSIGN_ROUND_EN
      mag_q = rounded[FRAC_BITS] ? '1 : rounded[FRAC_BITS-1:0];
`else
      mag_q = quo_q;
`endif
    end
  end

  assign mag_ext    = {{(WIDTH-FRAC_BITS){1'b0}}, mag_q};
  assign signed_res = sign_q ? (WIDTH'(0) - mag_ext) : mag_ext;

  // NOTE: state register and all datapath flops use non-blocking assignments so every
  // flop samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = load_err ? SIGN : DIV;
      DIV:     if (count_q == CW'(ITER - 1)) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every register, including the latched operands, is cleared by reset so an
  // aborted operation leaves no stale state behind.
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      denom_q <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      count_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div_err <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_q     <= X;
            denom_q <= denom;
            sign_q  <= X[WIDTH-1];
          end
        end
        LOAD: begin
          busy    <= 1'b1;
          err_q   <= load_err;
          rem_q   <= {1'b0, mag};
          quo_q   <= '0;
          count_q <= '0;
        end
        DIV: begin
          rem_q   <= rem_nxt;
          quo_q   <= {quo_q[ITER-2:0], quo_bit};
          count_q <= count_q + CW'(1);
        end
        SIGN: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          div_err <= err_q;
          result  <= signed_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softsign_divider.sv
// Self-checking bench for softsign_divider: timeline/arithmetic reference model plus directed vectors.
module tb_softsign_divider;
  localparam int W = 32;
  localparam int F = 16;
`ifdef SOFTSIGN_ROUND_EN
  localparam int LAT_N = F + 3;
  localparam logic [31:0] R23 = 32'h0000AAAB;
`else
  localparam int LAT_N = F + 2;
  localparam logic [31:0] R23 = 32'h0000AAAA;
`endif

  logic CLOCK = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] X = '0, denom = '0;
  logic busy, done, div_err;
  logic [W-1:0] result;

  int tests = 0, fails = 0;
  int cyc = 0, n_done = 0;

  bit m_active = 0;
  int m_start = 0, m_done = 0;
  logic e_busy = 0, e_done = 0, e_err = 0, p_err = 0;
  logic [31:0] e_res = '0, p_res = '0;

  always #5 CLOCK = ~CLOCK;

  softsign_divider #(.WIDTH(W), .FRAC_BITS(F)) dut (
    .CLOCK(CLOCK), .reset(reset), .start(start), .X(X), .denom(denom),
    .busy(busy), .done(done), .result(result), .div_err(div_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Softsign from plain arithmetic: floor (or round-half-up) of |x|*2^F/d, then sign.
  function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [31:0] d,
                                             output logic err);
    longint unsigned mag, q, lim, dd;
    lim = (64'd1 << F) - 1;
    dd  = {32'd0, d};
    mag = x[31] ? (64'd4294967296 - {32'd0, x}) : {32'd0, x};
    if (dd == 0 || dd <= mag) begin
      err = 1'b1;
      q   = lim;
    end else begin
      err = 1'b0;
`ifdef SOFTSIGN_ROUND_EN
      q = (((mag << (F + 1)) / dd) + 1) >> 1;
      if (q > lim) q = lim;
`else
      q = (mag << F) / dd;
`endif
    end
    return x[31] ? 32'(64'd0 - q) : 32'(q);
  endfunction

  // Reference timeline and per-cycle compare.
  initial begin
    forever begin
      @(posedge CLOCK);
      cyc++;
      if (!reset) begin
        m_active = 0; e_busy = 0; e_done = 0; e_res = '0; e_err = 0;
      end else if (!m_active) begin
        e_done = 0;
        if (start) begin
          m_active = 1;
          m_start  = cyc;
          p_res    = ref_result(X, denom, p_err);
          m_done   = cyc + (p_err ? 2 : LAT_N);
        end
      end else begin
        if (cyc == m_start + 1) e_busy = 1;
        if (cyc == m_done) begin
          e_busy = 0; e_done = 1; e_res = p_res; e_err = p_err; m_active = 0;
        end
      end
      #1;
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("result", result, e_res);
      check("div_err", div_err, e_err);
      if (done === 1'b1) n_done++;
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] d, input int gap,
                        output int lat, output logic [31:0] r, output logic e);
    int s;
    repeat (gap) @(negedge CLOCK);
    @(negedge CLOCK);
    start = 1'b1; X = x; denom = d;
    @(posedge CLOCK); #2;
    s = cyc;
    @(negedge CLOCK);
    start = 1'b0; X = $urandom; denom = $urandom;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLOCK); #2;
      if (done === 1'b1) begin
        lat = cyc - s;
        break;
      end
    end
    r = result;
    e = div_err;
  endtask

  initial begin
    int lat, s, nb, nd, gap, sel;
    logic [31:0] r, x, d, mg;
    logic e, re;

    #2 reset = 1'b0;
    repeat (2) @(posedge CLOCK);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", div_err, 0);
    @(negedge CLOCK) reset = 1'b1;

    run_op(32'd1, 32'd2, 1, lat, r, e);
    check("x1_lat", lat, LAT_N); check("x1_res", r, 32'h00008000); check("x1_err", e, 0);
    run_op(32'hFFFFFFFD, 32'd4, 0, lat, r, e);
    check("xm3_res", r, 32'hFFFF4000); check("xm3_err", e, 0);
    run_op(32'h80000000, 32'h80000001, 2, lat, r, e);
    check("xmin_res", r, 32'hFFFF0001); check("xmin_err", e, 0);
    run_op(32'd0, 32'd1, 0, lat, r, e);
    check("x0_res", r, 32'h0);
    run_op(32'd5, 32'd0, 1, lat, r, e);
    check("d0_lat", lat, 2); check("d0_res", r, 32'h0000FFFF); check("d0_err", e, 1);
    run_op(32'd5, 32'd5, 0, lat, r, e);
    check("deq_err", e, 1); check("deq_res", r, 32'h0000FFFF);
    run_op(32'd2, 32'd3, 0, lat, r, e);
    check("x2d3_res", r, R23); check("x2d3_lat", lat, LAT_N);

    // Extra start pulses while busy must be ignored.
    nd = n_done;
    @(negedge CLOCK);
    start = 1'b1; X = 32'd1; denom = 32'd2;
    @(posedge CLOCK); #2;
    s = cyc; nb = 0; lat = -1;
    for (int k = 1; k < 40; k++) begin
      @(negedge CLOCK);
      start = (k == 3 || k == 10); X = $urandom; denom = $urandom;
      @(posedge CLOCK); #2;
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin
        lat = cyc - s;
        break;
      end
    end
    start = 1'b0;
    check("ign_lat", lat, LAT_N);
    check("ign_res", result, 32'h00008000);
    check("ign_busy_cycles", nb, LAT_N - 1);
    check("ign_single_done", n_done - nd, 1);
    run_op(32'hFFFFFFFD, 32'd4, 0, lat, r, e);
    check("b2b_lat", lat, LAT_N); check("b2b_res", r, 32'hFFFF4000);

    // Asynchronous reset mid-operation.
    @(negedge CLOCK);
    start = 1'b1; X = 32'd1; denom = 32'd2;
    @(negedge CLOCK);
    start = 1'b0;
    repeat (8) @(posedge CLOCK);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_err", div_err, 0);
    nd = n_done;
    repeat (2) @(negedge CLOCK);
    reset = 1'b1;
    repeat (25) @(posedge CLOCK);
    #2;
    check("abort_no_done", n_done - nd, 0);
    run_op(32'd1, 32'd2, 0, lat, r, e);
    check("post_rst_lat", lat, LAT_N); check("post_rst_res", r, 32'h00008000);

    // Randomized operations; the compare process checks every cycle.
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 4);
      gap = $urandom_range(0, 2);
      x = $urandom;
      if (sel == 4) x = 32'($urandom_range(0, 400)) - 32'd200;
      mg = x[31] ? (32'd0 - x) : x;
      case (sel)
        0:       d = mg + 32'd1;
        1:       d = $urandom;
        2:       d = 32'd0;
        3:       d = mg;
        default: d = 32'($urandom_range(1, 300));
      endcase
      void'(ref_result(x, d, re));
      run_op(x, d, gap, lat, r, e);
      check("rnd_lat", lat, re ? 2 : LAT_N);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
